fifo_buffer: RTL and testbench

Synchronous single-clock FIFO with 32-bit data and 8 entries. It decouples a producer and a consumer within one clock domain and exposes EMPTY/FULL status flags. A global enable gates all activity. Reads return data through a registered output port.

---
 rtl/fifo_buffer.sv | 93 +++++++++
 tb/tb_fifo_buffer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fifo_buffer.sv
// ----------------------------------------------------------------------------
// fifo_buffer
//   Synchronous single-clock FIFO. It decouples a producer from a consumer in
//   the same clock domain. Read data comes out through a registered port with
//   one cycle of latency. The EMPTY and FULL flags are decoded from the
//   registered occupancy count, so there is no combinational path from the
//   inputs to the flags.
//
// Ports
//   Clk     in   rising-edge clock
//   Rst     in   synchronous reset, active low (wins over EN/WR/RD)
//   EN      in   global enable; when low, no read or write and all state holds
//   WR      in   write request (dropped while FULL)
//   RD      in   read request (ignored while EMPTY)
//   dataIn  in   word to be written
//   dataOut out  registered read data; holds unless a read is accepted
//   EMPTY   out  FIFO holds 0 words
//   FULL    out  FIFO holds DEPTH words
// ----------------------------------------------------------------------------
module fifo_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  EN,
    input  logic                  WR,
    input  logic                  RD,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  EMPTY,
    output logic                  FULL
);

    localparam int CW = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wp;
    logic [ADDR_WIDTH-1:0] r_rp;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_dout;

    logic w_empty;
    logic w_full;
    logic w_wr_ok;
    logic w_rd_ok;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // Acceptance is qualified by the registered flags. On the same cycle, a
    // write into an empty FIFO cannot be read, and a read from a full FIFO
    // cannot free space for a write.
    assign w_wr_ok = EN & WR & ~w_full;
    assign w_rd_ok = EN & RD & ~w_empty;

    // Storage is not reset. The write is suppressed while Rst is low, so
    // reset also wins for the memory array.
    always_ff @(posedge Clk) begin
        if (Rst && w_wr_ok) begin
            r_mem[r_wp] <= dataIn;
        end
    end

    // Pointers wrap naturally at ADDR_WIDTH bits because DEPTH is a power of two.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_dout  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wp <= r_wp + ADDR_WIDTH'(1);
            end
            if (w_rd_ok) begin
                r_rp   <= r_rp + ADDR_WIDTH'(1);
                r_dout <= r_mem[r_rp];
            end
            if (w_wr_ok && !w_rd_ok) begin
                r_count <= r_count + CW'(1);
            end else if (w_rd_ok && !w_wr_ok) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign dataOut = r_dout;
    assign EMPTY   = w_empty;
    assign FULL    = w_full;

endmodule

// File: tb/tb_fifo_buffer.sv
// ----------------------------------------------------------------------------
// tb_fifo_buffer
//   Self-checking bench for fifo_buffer. A queue models the buffered words.
//   Each accepted write pushes its word onto the queue. Each accepted read
//   pops the front word, which becomes the expected dataOut. After every edge,
//   dataOut, EMPTY and FULL are compared against the model.
// ----------------------------------------------------------------------------
module tb_fifo_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic          wr  = 1'b0;
    logic          rd  = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          empty;
    logic          full;

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;

    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] m_dout = '0;

    fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .Clk     (clk),
        .Rst     (rst),
        .EN      (en),
        .WR      (wr),
        .RD      (rd),
        .dataIn  (din),
        .dataOut (dout),
        .EMPTY   (empty),
        .FULL    (full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle. Model the edge from the state before it, then compare.
    task automatic step(input logic r_n, input logic e, input logic w, input logic r,
                        input logic [DW-1:0] d, input string tag);
        bit m_wr;
        bit m_rd;
        rst = r_n; en = e; wr = w; rd = r; din = d;
        m_wr = r_n && e && w && (sb_q.size() < DEPTH);
        m_rd = r_n && e && r && (sb_q.size() > 0);
        @(posedge clk);
        #1;
        if (!r_n) begin
            sb_q.delete();
            m_dout = '0;
        end else begin
            if (m_rd) m_dout = sb_q.pop_front();
            if (m_wr) sb_q.push_back(d);
        end
        check_eq({tag, ".dout"},  dout,               m_dout);
        check_eq({tag, ".empty"}, DW'(empty),         DW'(sb_q.size() == 0));
        check_eq({tag, ".full"},  DW'(full),          DW'(sb_q.size() == DEPTH));
    endtask

    task automatic wr_word(input logic [DW-1:0] d, input string tag);
        step(1'b1, 1'b1, 1'b1, 1'b0, d, tag);
    endtask

    task automatic rd_word(input string tag);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'hBAD0_BAD0, tag);
    endtask

    initial begin
        // Reset with EN and WR held high: nothing may be written.
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, "rst0");
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, "rst1");
        rd_word("rst_rd");

        // Write 0..4, then read five and hold.
        for (int i = 0; i < 5; i++) wr_word(DW'(i), "wr5");
        for (int i = 0; i < 7; i++) rd_word("rd5");

        // Fill the FIFO, try to overflow it, then drain.
        for (int i = 0; i < 8; i++) wr_word(DW'(32'h10 + i), "fill");
        wr_word(32'hFF, "ovf");
        for (int i = 0; i < 9; i++) rd_word("drain");

        // Pointer wrap-around.
        for (int i = 0; i < 6; i++) wr_word(DW'(32'h20 + i), "wrapw1");
        for (int i = 0; i < 4; i++) rd_word("wrapr1");
        for (int i = 0; i < 6; i++) wr_word(DW'(32'h30 + i), "wrapw2");
        check_eq("wrap_full", DW'(full), 32'd1);
        for (int i = 0; i < 8; i++) rd_word("wrapr2");

        // Simultaneous read and write with 3 words held.
        for (int i = 0; i < 3; i++) wr_word(DW'(32'h40 + i), "simw");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b1, DW'(32'h50 + i), "simrw");
        check_eq("sim_cnt", DW'(sb_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) rd_word("simdr");

        // Enable gating.
        wr_word(32'h60, "enw"); wr_word(32'h61, "enw"); rd_word("enr");
        wr_word(32'h62, "enw");
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'(i & 1), 1'(~i & 1), DW'(32'h70 + i), "engate");
        for (int i = 0; i < 3; i++) rd_word("enres");

        // Simultaneous read and write while empty.
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hA5, "emprw");
        rd_word("emprd");

        // Reset with 5 words held; the next word must come out first.
        for (int i = 0; i < 5; i++) wr_word(DW'(32'h80 + i), "prerst");
        step(1'b0, 1'b1, 1'b0, 1'b1, '0, "midrst");
        wr_word(32'h99, "postrst");
        rd_word("postrst_rd");

        // Randomised traffic.
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0),
                 1'($urandom), 1'($urandom), DW'($urandom), "rand");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
